// File: rtl/product_accumulator_8bits_4bits.sv
// rtl/product_accumulator_8bits_4bits.sv - accumulates 12-bit multiplier products (full or two-lane half mode) per vector
module product_accumulator_8bits_4bits #(
  parameter int C_WIDTH = 12,
  parameter int GUARD   = 8,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [C_WIDTH-1:0]         C,
  input  logic                       A_sign,
  input  logic                       B_sign,
  input  logic                       HALF_1,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  input  logic                       acc_clr,
  output logic [C_WIDTH+GUARD-1:0]   acc_out,
  output logic                       out_half,
  output logic [CNT_W-1:0]           out_count,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int ACC_W  = C_WIDTH + GUARD;
  localparam int HC     = C_WIDTH / 2;
  localparam int LANE_W = HC + GUARD / 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               half_q, half_d;
  logic               out_valid_q, out_valid_d;

  logic               sgn;
  logic               beat;
  logic               fresh;
  logic               mode;
  logic [ACC_W-1:0]   ext_full;
  logic [ACC_W-1:0]   ext_half;
  logic [ACC_W-1:0]   base;
  logic [ACC_W-1:0]   sum;
  logic [LANE_W-1:0]  lane0_sum;
  logic [LANE_W-1:0]  lane1_sum;
  logic [CNT_W-1:0]   count_inc;

  // Only DONE can stall the input; it follows downstream readiness there.
  assign in_ready  = (state_q == S_DONE) ? out_ready : 1'b1;
  assign beat      = in_valid & in_ready;
  assign acc_out   = acc_q;
  assign out_half  = half_q;
  assign out_count = count_q;
  assign out_valid = out_valid_q;

  // Extend the beat, pick the base (zero for a new vector) and form the wrapped sum.
  always_comb begin
    sgn      = A_sign | B_sign;
    ext_full = {{GUARD{sgn & C[C_WIDTH-1]}}, C};
    ext_half = {{(GUARD/2){sgn & C[C_WIDTH-1]}}, C[C_WIDTH-1:HC],
                {(GUARD/2){sgn & C[HC-1]}}, C[HC-1:0]};
    // Any beat taken outside ACC starts a fresh vector and latches HALF_1.
    fresh     = (state_q != S_ACC);
    mode      = fresh ? HALF_1 : half_q;
    base      = fresh ? '0 : acc_q;
    lane0_sum = base[LANE_W-1:0] + ext_half[LANE_W-1:0];
    lane1_sum = base[ACC_W-1:LANE_W] + ext_half[ACC_W-1:LANE_W];
    sum       = mode ? {lane1_sum, lane0_sum} : (base + ext_full);
    count_inc = fresh ? CNT_W'(1) : ((&count_q) ? count_q : count_q + CNT_W'(1));
  end

  // Next-state and datapath update; acc_clr overrides everything.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    half_d  = half_q;
    case (state_q)
      S_IDLE, S_ACC: begin
        if (beat) begin
          acc_d   = sum;
          count_d = count_inc;
          half_d  = mode;
          state_d = in_last ? S_DONE : S_ACC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          if (beat) begin
            acc_d   = sum;
            count_d = count_inc;
            half_d  = mode;
            state_d = in_last ? S_DONE : S_ACC;
          end else begin
            acc_d   = '0;
            count_d = '0;
            half_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        acc_d   = '0;
        count_d = '0;
        half_d  = 1'b0;
      end
    endcase
    if (acc_clr) begin
      state_d = S_IDLE;
      acc_d   = '0;
      count_d = '0;
      half_d  = 1'b0;
    end
    out_valid_d = (state_d == S_DONE);
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      half_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      half_q      <= half_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: doc/product_accumulator_8bits_4bits.md
# product_accumulator_8bits_4bits

Downstream consumer of the 8x4 precision-configurable multiplier. It takes the 12-bit product word `C` once per accepted beat and accumulates it over a vector delimited by `in_last`. In full mode the product is one 12-bit value; in half mode it is two packed 6-bit lane products. It sign-extends per the operand signedness and presents the registered sum through a valid/ready handshake to the next stage (output writer / requantiser).

## Interface
Parameters:
- `C_WIDTH`, 12, product word width from the multiplier (fixed 12; lanes are `C_WIDTH/2`).
- `GUARD`, 8, accumulator guard bits. Full accumulator is `C_WIDTH+GUARD` (20). Each half lane is `C_WIDTH/2+GUARD/2` (10).
- `CNT_W`, 8, width of the beat counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `C`  in  12  product word from the multiplier.
- `A_sign`  in  1  A operand signed, sampled with the beat.
- `B_sign`  in  1  B operand signed, sampled with the beat.
- `HALF_1`  in  1  1 = two-lane half mode. Latched on the first beat of a vector.
- `in_valid`  in  1  product beat valid.
- `in_last`  in  1  final beat of the vector.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`.
- `acc_clr`  in  1  synchronous abort: discard the vector and return to IDLE.
- `acc_out`  out  20  result. Full: [19:0]. Half: lane0 [9:0], lane1 [19:10].
- `out_half`  out  1  mode of `acc_out`.
- `out_count`  out  8  beats in the vector, saturating at 255.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts when `out_valid & out_ready`.

## Operation
- Signedness per beat: `sgn = A_sign | B_sign`.
- Full mode: `C[11:0]` is extended to 20 bits, sign-extended when `sgn`, else zero-extended.
- Half mode: `C[5:0]` is extended to 10 bits into lane0 and `C[11:6]` to 10 bits into lane1, each by `sgn`.
- Lanes are added independently. No carry crosses bit 9→10 in half mode.
- All sums wrap modulo the accumulator/lane width. There is no saturation and no overflow flag.
- State machine:
  - IDLE: acc = 0, count = 0, `in_ready = 1`.
    - Accepted beat: acc ← ext(C), count ← 1, mode latched.
    - Goes to ACC, or to DONE if `in_last`.
  - ACC: `in_ready = 1`.
    - Accepted beat: acc ← acc + ext(C), count ← sat(count+1).
    - Goes to DONE on `in_last`.
    - `HALF_1` is ignored after the first beat.
  - DONE: `out_valid = 1`; `acc_out`, `out_half` and `out_count` are stable; `in_ready = out_ready`.
    - If `out_ready` and no beat is accepted: go to IDLE.
    - If `out_ready` and a beat is accepted: that beat starts a new vector from zero (not added to the old sum). Go to ACC, or stay in DONE if `in_last`.
- `acc_clr` has priority over everything in every state. Next state is IDLE, acc and count are 0, `out_valid` is 0. A beat offered in the same cycle is dropped even though `in_ready` was high.
- `out_count` saturates at 255. Accumulation continues past 255.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `acc_out` = 0, `out_half` = 0, `out_count` = 0, state = IDLE.
- An asynchronous `rst_n` assertion mid-vector discards all partial state immediately.
- Latency: the `in_last` beat is accepted at edge k; `out_valid` = 1 and the result includes that beat from after edge k.
- Throughput: one beat per cycle. A back-to-back vector is possible with zero bubble when `out_ready` = 1 in DONE.
- All outputs are registered except `in_ready`, which is combinational from state and `out_ready`.
- `out_valid` stays high and `acc_out` holds until `out_ready`. A downstream stall propagates to `in_ready` = 0.
- Single-beat vector (`in_last` on the first beat) goes directly from IDLE to DONE.

## Test plan
- Full signed, 3 beats of `C`=12'hFF1 (−15), `A_sign`=1, `in_last` on the 3rd → `acc_out`=20'hFFFD3 (−45), `out_count`=3, `out_half`=0, valid one edge after the last beat.
- Half unsigned, 2 beats of `C`={6'd10,6'd6} → lane0 = 10'd12, lane1 = 10'd20. Lane0 all-ones with `sgn`=1 (6'h3F) over 2 beats → lane0 = 10'h3FE, lane1 unaffected.
- Full unsigned wrap, 257 beats of 12'hFFF → `acc_out`=20'h00EFF, `out_count`=255.
- Back-pressure: hold `out_ready`=0 for 5 cycles in DONE → `acc_out` stable, `in_ready`=0. Then `out_ready`=1 with a new beat 12'h005 `in_last` → the next result is 20'h00005, not added to the old sum.
- `acc_clr` in ACC with a concurrent beat → next cycle IDLE, acc = 0, beat dropped. A following 1-beat vector of 12'h010 → 20'h00010.
- `rst_n` low for 1 cycle after 2 beats → all outputs at reset values. The next 1-beat vector of 12'h001 → 20'h00001, count = 1.
